// File: rtl/byte_masking_pkg.sv
// -----------------------------------------------------------------------------
// byte_masking_pkg
// Shared definitions for the byte-masked scratch RAM:
//   - default address/data widths
//   - byte-lane mask and word typedefs
//   - merge_bytes(): lane-wise merge of a new word into an old word
// -----------------------------------------------------------------------------
package byte_masking_pkg;

    localparam int BM_ADDR_W    = 8;
    localparam int BM_DATA_W    = 32;
    localparam int BM_NUM_BYTES = BM_DATA_W / 8;

    typedef logic [BM_NUM_BYTES-1:0] lane_mask_t;
    typedef logic [BM_DATA_W-1:0]    word_t;

    // Lane i of the result comes from new_w when mask[i] is set, otherwise
    // from old_w. Lane 0 is bits [7:0] (little-endian lane numbering).
    function automatic word_t merge_bytes(input word_t      old_w,
                                          input word_t      new_w,
                                          input lane_mask_t mask);
        word_t res;
        res = old_w;
        for (int i = 0; i < BM_NUM_BYTES; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/byte_masking_if.sv
// -----------------------------------------------------------------------------
// byte_masking_if
// Access bus of the byte-masked RAM.
//   c_en    : chip enable, no access when low
//   addr    : word address
//   wr      : 1 = write, 0 = read (qualified by c_en)
//   w_mask  : byte-lane write enables, bit i -> wr_data[8i+7:8i]
//   wr_data : write data
//   rd_data : registered read data (one-cycle latency)
// Modports: master drives the request, slave is the memory.
// -----------------------------------------------------------------------------
interface byte_masking_if
    import byte_masking_pkg::*;
#(
    parameter int ADDR_W = BM_ADDR_W,
    parameter int DATA_W = BM_DATA_W
) ();

    localparam int NUM_BYTES = DATA_W / 8;

    logic                 c_en;
    logic [ADDR_W-1:0]    addr;
    logic                 wr;
    logic [NUM_BYTES-1:0] w_mask;
    logic [DATA_W-1:0]    wr_data;
    logic [DATA_W-1:0]    rd_data;

    modport master (
        output c_en, addr, wr, w_mask, wr_data,
        input  rd_data
    );

    modport slave (
        input  c_en, addr, wr, w_mask, wr_data,
        output rd_data
    );

endinterface

// File: rtl/byte_masking.sv
// -----------------------------------------------------------------------------
// byte_masking
// Single-port synchronous RAM (2**ADDR_W x DATA_W) with per-byte write mask.
//   clk : system clock, all state changes on the rising edge
//   rst : synchronous active-high reset; clears every word and rd_data
//   bus : byte_masking_if.slave (c_en, addr, wr, w_mask, wr_data, rd_data)
// Writes update only the lanes selected by w_mask; reads return the full word
// through a register one cycle later. rd_data holds across writes and idle
// cycles. Built from flops so that reset can clear the whole array.
// -----------------------------------------------------------------------------
module byte_masking
    import byte_masking_pkg::*;
#(
    parameter int ADDR_W = BM_ADDR_W,
    parameter int DATA_W = BM_DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    byte_masking_if.slave bus
);

    localparam int NUM_BYTES = DATA_W / 8;
    localparam int DEPTH     = 2 ** ADDR_W;

    // The lane merge lives in the package and is typed at the package width.
    if (DATA_W != BM_DATA_W || (DATA_W % 8) != 0) begin : g_bad_width
        $error("byte_masking: DATA_W must equal byte_masking_pkg::BM_DATA_W and be a multiple of 8");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] w_merged;

    assign w_merged = merge_bytes(r_mem[bus.addr], bus.wr_data, bus.w_mask);

    // Reset wins over any access in the same cycle and never looks at the
    // control inputs, so X on them during reset cannot leak into state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.c_en) begin
            if (bus.wr) begin
                r_mem[bus.addr] <= w_merged;
            end else begin
                r_rd_data <= r_mem[bus.addr];
            end
        end
    end

    assign bus.rd_data = r_rd_data;

endmodule

// File: tb/tb_byte_masking.sv
// -----------------------------------------------------------------------------
// tb_byte_masking
// Self-checking bench for byte_masking: directed scenarios followed by random
// traffic, all compared against a byte-array reference model.
// -----------------------------------------------------------------------------
module tb_byte_masking;

    logic clk;
    logic rst;

    byte_masking_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    byte_masking #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: memory as an array of bytes, read data as a word.
    byte unsigned  mdl_mem [256][4];
    logic [31:0]   mdl_rd;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mdl_word(input int a);
        return {mdl_mem[a][3], mdl_mem[a][2], mdl_mem[a][1], mdl_mem[a][0]};
    endfunction

    // Apply one cycle of inputs, update the model at the edge, and check
    // rd_data 1 ns after the edge.
    task automatic step(input string tag, input bit r, input bit ce, input bit w,
                        input logic [7:0] a, input logic [3:0] m, input logic [31:0] d);
        rst         = r;
        bus.c_en    = ce;
        bus.wr      = w;
        bus.addr    = a;
        bus.w_mask  = m;
        bus.wr_data = d;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 256; i++)
                for (int j = 0; j < 4; j++)
                    mdl_mem[i][j] = 8'h00;
            mdl_rd = 32'h0;
        end else if (ce) begin
            if (w) begin
                for (int j = 0; j < 4; j++)
                    if (m[j]) mdl_mem[a][j] = d[8*j +: 8];
            end else begin
                mdl_rd = mdl_word(int'(a));
            end
        end
        #1;
        check_val(tag, bus.rd_data, mdl_rd);
    endtask

    task automatic do_write(input string tag, input logic [7:0] a, input logic [3:0] m, input logic [31:0] d);
        step(tag, 1'b0, 1'b1, 1'b1, a, m, d);
    endtask

    task automatic do_read(input string tag, input logic [7:0] a);
        step(tag, 1'b0, 1'b1, 1'b0, a, $urandom_range(0, 15), $urandom);
    endtask

    initial begin
        rst         = 1'b1;
        bus.c_en    = 1'b0;
        bus.wr      = 1'b0;
        bus.addr    = '0;
        bus.w_mask  = '0;
        bus.wr_data = '0;
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < 4; j++)
                mdl_mem[i][j] = 8'hA5;
        mdl_rd = 32'hFFFF_FFFF;

        // Reset clear, with live-looking controls on the bus during reset
        step("reset_rd", 1'b1, 1'b1, 1'b1, 8'd9, 4'hF, 32'hCAFE_F00D);
        do_read("rd_addr0", 8'd0);
        check_val("rd_addr0_const", bus.rd_data, 32'h0);
        do_read("rd_addr128", 8'd128);
        do_read("rd_addr255", 8'd255);
        check_val("rd_addr255_const", bus.rd_data, 32'h0);

        // Masked writes to the top word
        do_write("wr255_nomask", 8'd255, 4'b0000, 32'h0000_0007);
        do_read("rd255_nomask", 8'd255);
        check_val("rd255_nomask_const", bus.rd_data, 32'h0);
        do_write("wr255_lane0", 8'd255, 4'b0001, 32'h0000_0005);
        do_read("rd255_lane0", 8'd255);
        check_val("rd255_lane0_const", bus.rd_data, 32'h0000_0005);

        // Lane isolation
        do_write("wr10_full", 8'd10, 4'b1111, 32'hAABB_CCDD);
        do_write("wr10_0101", 8'd10, 4'b0101, 32'h1122_3344);
        do_read("rd10_0101", 8'd10);
        check_val("rd10_0101_const", bus.rd_data, 32'hAA22_CC44);
        do_write("wr10_full2", 8'd10, 4'b1111, 32'hAABB_CCDD);
        do_write("wr10_1010", 8'd10, 4'b1010, 32'h1122_3344);
        do_read("rd10_1010", 8'd10);
        check_val("rd10_1010_const", bus.rd_data, 32'h11BB_33DD);

        // Chip enable gating
        step("cen0_wr", 1'b0, 1'b0, 1'b1, 8'd3, 4'hF, 32'hFFFF_FFFF);
        check_val("cen0_wr_hold", bus.rd_data, 32'h11BB_33DD);
        step("cen0_rd", 1'b0, 1'b0, 1'b0, 8'd255, 4'h0, 32'h0);
        check_val("cen0_rd_hold", bus.rd_data, 32'h11BB_33DD);
        do_read("rd3_gated", 8'd3);
        check_val("rd3_gated_const", bus.rd_data, 32'h0);

        // Write then read on the next edge; rd_data holds during the write
        do_read("rd255_pre", 8'd255);
        do_write("wr7", 8'd7, 4'b1111, 32'h1234_5678);
        check_val("wr7_rd_hold", bus.rd_data, 32'h0000_0005);
        do_read("rd7", 8'd7);
        check_val("rd7_const", bus.rd_data, 32'h1234_5678);

        // Reset priority over a simultaneous write
        do_write("wr5_pre", 8'd5, 4'b1111, 32'h0102_0304);
        step("rst_with_wr", 1'b1, 1'b1, 1'b1, 8'd5, 4'hF, 32'hDEAD_BEEF);
        check_val("rst_with_wr_const", bus.rd_data, 32'h0);
        do_read("rd5_after_rst", 8'd5);
        check_val("rd5_after_rst_const", bus.rd_data, 32'h0);
        do_read("rd7_after_rst", 8'd7);

        // Random traffic over a small address window plus the top word
        for (int k = 0; k < 600; k++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 15));
            step("rand", ($urandom_range(0, 79) == 0), ($urandom_range(0, 5) != 0),
                 $urandom_range(0, 1) == 1, a, 4'($urandom_range(0, 15)), $urandom);
        end

        // Final sweep of the random window
        for (int a = 0; a < 16; a++) begin
            do_read("sweep", 8'(a));
        end
        do_read("sweep", 8'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
